// File: rtl/hpdcache_rr_1hot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_rr_1hot_arbiter
//  Purpose  : N-way one-hot arbiter with round-robin rotating priority and a
//             valid/ready handshake. A granted requester that is stalled by
//             the consumer keeps its grant until it is accepted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N        number of requesters (>= 1)
//    RR_EN    1: rotating priority, 0: fixed priority (lowest index wins)
//    LOCK_EN  1: hold grant while stalled, 0: re-arbitrate every cycle
//    IDXW     index width, derived from N (do not override)
//  Ports
//    clk_i      clock, all state updates on the rising edge
//    rst_ni     synchronous active-low reset
//    req_i      request vector, bit i belongs to requester i
//    gnt_o      one-hot grant, all-zero when nothing is granted
//    gnt_idx_o  binary index of the granted requester (0 when no grant)
//    valid_o    a grant is being presented to the consumer
//    ready_i    consumer accepts the granted request this cycle
//    ptr_o      current highest-priority index
// ============================================================================
module hpdcache_rr_1hot_arbiter #(
    parameter int unsigned N       = 4,
    parameter bit          RR_EN   = 1'b1,
    parameter bit          LOCK_EN = 1'b1,
    parameter int unsigned IDXW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [IDXW-1:0] ptr_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDXW-1:0] r_ptr;
    logic            r_lock;
    logic [N-1:0]    r_gnt;

    // ------------------------------------------------------------------------
    // Rotating-priority arbitration
    // ------------------------------------------------------------------------
    logic [N-1:0]    w_mask;
    logic [2*N-1:0]  w_dbl;
    logic [2*N-1:0]  w_first;
    logic [N-1:0]    w_arb;
    logic            w_hold;
    logic [N-1:0]    w_gnt;
    logic [IDXW-1:0] w_idx;
    logic            w_valid;
    logic [IDXW-1:0] w_ptr_inc;

    // Bits at or above the pointer keep their request in the low half.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (IDXW'(i) >= r_ptr);
        end
    end

    // Low half holds requests from ptr upward, high half holds the full
    // vector so indices below ptr are reached after wrapping. Isolating the
    // lowest set bit of the concatenation yields the round-robin winner.
    assign w_dbl   = {req_i, req_i & w_mask};
    assign w_first = w_dbl & (-w_dbl);
    assign w_arb   = w_first[N-1:0] | w_first[2*N-1:N];

    // A locked grant survives only while its requester still asserts req;
    // otherwise the lock is dropped and the fresh arbitration result wins.
    assign w_hold = LOCK_EN && r_lock && (|(r_gnt & req_i));

    // Outputs are forced idle for as long as reset is asserted.
    assign w_gnt   = !rst_ni ? '0 : (w_hold ? r_gnt : w_arb);
    assign w_valid = |w_gnt;

    // One-hot to binary: OR together the indices of set bits.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_idx = w_idx | IDXW'(i);
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at N-1.
    assign w_ptr_inc = (w_idx == IDXW'(N - 1)) ? '0 : (w_idx + IDXW'(1));

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr  <= '0;
            r_lock <= 1'b0;
            r_gnt  <= '0;
        end else if (w_valid && ready_i) begin
            r_lock <= 1'b0;
            r_ptr  <= RR_EN ? w_ptr_inc : '0;
        end else if (w_valid && LOCK_EN) begin
            r_lock <= 1'b1;
            r_gnt  <= w_gnt;
        end else if (!w_valid) begin
            r_lock <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt_o     = w_gnt;
    assign gnt_idx_o = w_idx;
    assign valid_o   = w_valid;
    assign ptr_o     = rst_ni ? r_ptr : '0;

endmodule
`default_nettype wire
